// File: rtl/dht11_responder.sv
// dht11_responder
//   Sensor-side model of the DHT11 single-wire bus. Waits for a host start
//   pulse, then answers with the response preamble and a 40-bit frame
//   (HumI, HumF, TempI, TempF, checksum; MSB first), driving the bus
//   open-drain (0 or released, never 1).
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   Data       open-drain bus (pulled up externally)
//   HumI/HumF  humidity integer / fraction byte
//   TempI/TempF temperature integer / fraction byte
//   busy       high while the response and frame are being sent
//   frame_done one-cycle pulse when the end marker has been released
//   start_err  one-cycle pulse on a too-short host low or a bus collision
module dht11_responder #(
  parameter int US_CYCLES    = 50,
  parameter int START_MIN_US = 18000,
  parameter int WAIT_US      = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_HIGH_US = 26,
  parameter int BIT1_HIGH_US = 70
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        Data,
  input  logic [7:0] HumI,
  input  logic [7:0] HumF,
  input  logic [7:0] TempI,
  input  logic [7:0] TempF,
  output logic       busy,
  output logic       frame_done,
  output logic       start_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HOST_LOW  = 3'd1;
  localparam logic [2:0] WAIT_REL  = 3'd2;
  localparam logic [2:0] RESP_LOW  = 3'd3;
  localparam logic [2:0] RESP_HIGH = 3'd4;
  localparam logic [2:0] BIT_LOW   = 3'd5;
  localparam logic [2:0] BIT_HIGH  = 3'd6;
  localparam logic [2:0] END_LOW   = 3'd7;

  // Last counter value of each phase (phase of N cycles ends at cnt == N-1).
  localparam logic [31:0] START_LAST  = 32'(START_MIN_US * US_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST   = 32'(WAIT_US * US_CYCLES - 1);
  localparam logic [31:0] RLOW_LAST   = 32'(RESP_LOW_US * US_CYCLES - 1);
  localparam logic [31:0] RHIGH_LAST  = 32'(RESP_HIGH_US * US_CYCLES - 1);
  localparam logic [31:0] BLOW_LAST   = 32'(BIT_LOW_US * US_CYCLES - 1);
  localparam logic [31:0] B0HIGH_LAST = 32'(BIT0_HIGH_US * US_CYCLES - 1);
  localparam logic [31:0] B1HIGH_LAST = 32'(BIT1_HIGH_US * US_CYCLES - 1);
  // Synchronizer latency window at the start of a released phase.
  localparam logic [31:0] COLL_MIN    = 32'd4;

  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic [5:0]  r_bit_idx;
  logic [39:0] r_shift;
  logic        r_sync1;
  logic        r_ds;
  logic        r_drive_low;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_start_err;
  logic        r_armed;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_high_last;
  logic [7:0]  w_csum;
  logic        w_start_ok;
  logic        w_short;
  logic        w_collide;
  logic        w_bit_end;
  logic        w_done;
  logic        w_drive_nxt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign Data       = r_drive_low ? 1'b0 : 1'bz;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign start_err  = r_start_err;

  // 8-bit wrap; carry discarded by the result width.
  assign w_csum      = HumI + HumF + TempI + TempF;
  assign w_high_last = r_shift[39] ? B1HIGH_LAST : B0HIGH_LAST;

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_short     = 1'b0;
    w_collide   = 1'b0;
    w_bit_end   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      // r_armed blocks the synchronizer tail of our own low phase (or a
      // collision low) from being taken as a new host start.
      IDLE: if (r_armed && !r_ds) w_state_nxt = HOST_LOW;
      HOST_LOW: begin
        if (r_ds) begin
          // cnt+1 samples of ds=0 have been seen when ds returns high.
          if (r_cnt >= START_LAST) begin
            w_state_nxt = WAIT_REL;
            w_start_ok  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_short     = 1'b1;
          end
        end
      end
      WAIT_REL: if (r_cnt == WAIT_LAST) w_state_nxt = RESP_LOW;
      RESP_LOW: if (r_cnt == RLOW_LAST) w_state_nxt = RESP_HIGH;
      RESP_HIGH: begin
        if (!r_ds && r_cnt >= COLL_MIN) begin
          w_state_nxt = IDLE;
          w_collide   = 1'b1;
        end else if (r_cnt == RHIGH_LAST) begin
          w_state_nxt = BIT_LOW;
        end
      end
      BIT_LOW: if (r_cnt == BLOW_LAST) w_state_nxt = BIT_HIGH;
      BIT_HIGH: begin
        if (!r_ds && r_cnt >= COLL_MIN) begin
          w_state_nxt = IDLE;
          w_collide   = 1'b1;
        end else if (r_cnt == w_high_last) begin
          w_bit_end   = 1'b1;
          w_state_nxt = (r_bit_idx == 6'd39) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        if (r_cnt == BLOW_LAST) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_drive_nxt = (w_state_nxt == RESP_LOW) || (w_state_nxt == BIT_LOW) ||
                       (w_state_nxt == END_LOW);

  // Control: state, counters, bus drive and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_drive_low  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_start_err  <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (w_state_nxt != r_state) ? 32'd0 : sat_inc(r_cnt);
      if (r_state == RESP_HIGH && w_state_nxt == BIT_LOW)
        r_bit_idx <= 6'd0;
      else if (w_bit_end)
        r_bit_idx <= r_bit_idx + 6'd1;
      r_drive_low  <= w_drive_nxt;
      r_busy       <= !((w_state_nxt == IDLE) || (w_state_nxt == HOST_LOW));
      r_frame_done <= w_done;
      r_start_err  <= w_short | w_collide;
      r_armed      <= (r_state == IDLE) && (r_armed || r_ds);
    end
  end

  // Datapath: bus synchronizer and frame shift register.
  always_ff @(posedge clk) begin
    r_sync1 <= Data;
    r_ds    <= r_sync1;
    if (w_start_ok)
      r_shift <= {HumI, HumF, TempI, TempF, w_csum};
    else if (w_bit_end)
      r_shift <= {r_shift[38:0], 1'b0};
  end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder
//   Drives host start pulses onto a pulled-up bus, decodes the responder's
//   waveform by run lengths and checks it against expected frames queued
//   at stimulus time.
module tb_dht11_responder;

  localparam int USC  = 2;
  localparam int SMIN = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] hi = 8'h00, hf = 8'h00, ti = 8'h00, tf = 8'h00;
  logic       busy, frame_done, start_err;
  wire        bus;

  assign bus = host_low ? 1'b0 : 1'bz;
  pullup (bus);

  dht11_responder #(.US_CYCLES(USC), .START_MIN_US(SMIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .Data       (bus),
    .HumI       (hi),
    .HumF       (hf),
    .TempI      (ti),
    .TempF      (tf),
    .busy       (busy),
    .frame_done (frame_done),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int fd_cnt = 0, se_cnt = 0, both_cnt = 0, busy_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (start_err) se_cnt <= se_cnt + 1;
    if (frame_done && start_err) both_cnt <= both_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Number of cycles the bus stays at lvl, sampled on falling edges.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (bus === lvl && len < 400) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic host_start(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
    #1;
  endtask

  // mode 0: normal, 1: change HumI to newv after bit arg,
  // 2: collision in RESP_HIGH, 3: reset during BIT_LOW of bit arg.
  task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input int mode, input int arg, input logic [7:0] newv);
    int wl, rl, rh, bl, bh, el, fd0, se0, lo_err, hi_err, total, exp_total, exp_h;
    int his[40];
    logic [39:0] got;
    logic [7:0]  e[5];
    logic [7:0]  cs;
    logic        eb;
    hi = b0; hf = b1; ti = b2; tf = b3;
    cs = b0 + b1 + b2 + b3;
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(cs);
    fd0 = fd_cnt; se0 = se_cnt;
    got = '0;
    host_start(200);
    run_len(1'b1, wl);
    check_val("wait_rel_len_in_61_65", 32'(wl >= 61 && wl <= 65), 1);
    run_len(1'b0, rl);
    check_val("resp_low_len", rl, 160);
    if (mode == 2) begin
      repeat (20) @(negedge clk);
      host_low = 1'b1;
      repeat (20) @(negedge clk);
      host_low = 1'b0;
      lo_err = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus !== 1'b1) lo_err++;
      end
      for (int k = 0; k < 5; k++) void'(exp_q.pop_front());
      check_val("coll_start_err", se_cnt - se0, 1);
      check_val("coll_frame_done", fd_cnt - fd0, 0);
      check_val("coll_busy", busy, 0);
      check_val("coll_bus_low_cycles", lo_err, 0);
      return;
    end
    run_len(1'b1, rh);
    check_val("resp_high_len", rh, 160);
    lo_err = 0;
    total = rl + rh;
    for (int i = 0; i < 40; i++) begin
      if (mode == 3 && i == arg) begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_bus_released", bus, 1);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) void'(exp_q.pop_front());
        repeat (20) @(negedge clk);
        check_val("rst_frame_done", fd_cnt - fd0, 0);
        check_val("rst_bus_idle", bus, 1);
        return;
      end
      run_len(1'b0, bl);
      if (bl != 100) lo_err++;
      run_len(1'b1, bh);
      his[i] = bh;
      got[39-i] = (bh > 96);
      total += bl + bh;
      if (mode == 1 && i == arg - 1) hi = newv;
    end
    run_len(1'b0, el);
    total += el;
    check_val("end_low_len", el, 100);
    check_val("bit_low_len_errs", lo_err, 0);
    for (int k = 0; k < 5; k++) begin
      e[k] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_val($sformatf("byte%0d", k), got[39-8*k -: 8], e[k]);
    end
    hi_err = 0;
    exp_total = 160 + 160 + 100;
    for (int i = 0; i < 40; i++) begin
      eb = e[i/8][7 - (i % 8)];
      exp_h = eb ? 140 : 52;
      if (his[i] != exp_h) hi_err++;
      exp_total += 100 + exp_h;
    end
    check_val("bit_high_len_errs", hi_err, 0);
    check_val("frame_len", total, exp_total);
    repeat (5) @(negedge clk);
    check_val("frame_done_count", fd_cnt - fd0, 1);
    check_val("frame_start_err", se_cnt - se0, 0);
    check_val("busy_after", busy, 0);
  endtask

  initial begin
    int lo, se0, b0, fd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_start_err", start_err, 0);
    check_val("rst_bus", bus, 1);
    repeat (10) @(negedge clk);

    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 0, 0, 8'h00);
    repeat (20) @(negedge clk);
    do_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 0, 0, 8'h00);
    repeat (20) @(negedge clk);

    se0 = se_cnt; b0 = busy_cnt; fd0 = fd_cnt;
    host_start(150);
    lo = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus !== 1'b1) lo++;
    end
    check_val("short_start_err", se_cnt - se0, 1);
    check_val("short_bus_low_cycles", lo, 0);
    check_val("short_busy_cycles", busy_cnt - b0, 0);
    check_val("short_frame_done", fd_cnt - fd0, 0);

    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 1, 10, 8'h40);
    repeat (20) @(negedge clk);
    do_frame(hi, 8'h00, 8'h19, 8'h05, 0, 0, 8'h00);
    check_val("snapshot_next_humi", hi, 8'h40);
    repeat (20) @(negedge clk);

    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 2, 0, 8'h00);
    repeat (20) @(negedge clk);

    do_frame(8'h12, 8'h34, 8'h56, 8'h78, 3, 12, 8'h00);
    repeat (20) @(negedge clk);
    do_frame(8'h12, 8'h34, 8'h56, 8'h78, 0, 0, 8'h00);

    check_val("queue_empty", exp_q.size(), 0);
    check_val("done_and_err_same_cycle", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
